// File: rtl/hamming_pkg.sv
`timescale 1ns/1ps
// hamming_pkg
// Shared definitions for the Hamming(7,4)+global-parity (SECDED) codeword
// used by the transmit encoder and the receive-side syndrome detector.
//   - bit positions of every codeword field
//   - codeword type
//   - serial transmitter FSM state encoding
//   - number of serial bit slots per frame (start + 8 data + stop)
package hamming_pkg;

    // Codeword layout, bit 7 down to bit 0: g0 w3 w2 w1 p2 w0 p1 p0.
    // Bits 0..6 correspond to classic Hamming positions 1..7.
    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_W0 = 2;
    localparam int POS_P2 = 3;
    localparam int POS_W1 = 4;
    localparam int POS_W2 = 5;
    localparam int POS_W3 = 6;
    localparam int POS_G0 = 7;

    localparam int FRAME_BITS = 10;

    typedef logic [7:0] codeword_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/hamming_encoder.sv
`timescale 1ns/1ps
// hamming_encoder
// Purely combinational SECDED encoder: 4-bit nibble -> 8-bit codeword.
// Ports:
//   data_i     [3:0]  data nibble {w3,w2,w1,w0}
//   codeword_o [7:0]  {g0,w3,w2,w1,p2,w0,p1,p0}
module hamming_encoder (
    input  logic [3:0] data_i,
    output logic [7:0] codeword_o
);
    import hamming_pkg::*;

    logic w0, w1, w2, w3;

    assign w0 = data_i[0];
    assign w1 = data_i[1];
    assign w2 = data_i[2];
    assign w3 = data_i[3];

    always_comb begin
        codeword_o         = '0;
        codeword_o[POS_W0] = w0;
        codeword_o[POS_W1] = w1;
        codeword_o[POS_W2] = w2;
        codeword_o[POS_W3] = w3;
        codeword_o[POS_P0] = w0 ^ w1 ^ w3;
        codeword_o[POS_P1] = w0 ^ w2 ^ w3;
        codeword_o[POS_P2] = w1 ^ w2 ^ w3;
        // Global parity covers the seven Hamming bits so that the whole
        // byte has even parity; this separates single from double errors.
        codeword_o[POS_G0] = ^codeword_o[6:0];
    end

endmodule

// File: rtl/hamming_secded_tx.sv
`timescale 1ns/1ps
// hamming_secded_tx
// Accepts a nibble on a valid/ready handshake, encodes it as a SECDED
// codeword, XORs an error-injection mask into it and sends the result on a
// UART-style line: one start bit (0), eight data bits LSB first, one stop
// bit (1), each bit lasting CLKS_PER_BIT clocks.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_i      [3:0] data nibble {w3,w2,w1,w0}
//   err_mask_i  [7:0] XOR mask applied at accept (0 = clean frame)
//   valid_i     data_i / err_mask_i valid
//   ready_o     high only while idle; accept = valid_i & ready_o
//   codeword_o  [7:0] last transmitted (masked) byte
//   tx_o        serial line, idles high
//   busy_o      frame in progress
//   done_o      one-cycle pulse in the last cycle of the stop bit
module hamming_secded_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_i,
    input  logic [7:0] err_mask_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] codeword_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    import hamming_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    codeword_t        shift_q, shift_d;
    codeword_t        codeword_q, codeword_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    codeword_t        enc_codeword;
    codeword_t        masked_codeword;
    logic             accept;
    logic             bit_end;

    hamming_encoder u_encoder (
        .data_i     (data_i),
        .codeword_o (enc_codeword)
    );

    assign masked_codeword = enc_codeword ^ err_mask_i;
    assign accept          = valid_i & ready_q;
    assign bit_end         = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        codeword_d = codeword_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d    = ST_START;
                    bit_idx_d  = 3'd0;
                    shift_d    = masked_codeword;
                    codeword_d = masked_codeword;
                end
            end
            ST_START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up exactly with the state they describe.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            codeword_q <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            codeword_q <= codeword_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ready_o    = ready_q;
    assign codeword_o = codeword_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: doc/hamming_secded_tx.md
Name: hamming_secded_tx

Overview:
Transmit-side counterpart of the SECDED syndrome detector. Accepts a 4-bit data nibble with a valid/ready handshake and encodes it into the team's 8-bit Hamming(7,4)+global-parity codeword. It applies an optional error-injection mask, then serializes the codeword on a single UART-style line. The receive board feeds the recovered byte into the syndrome detector.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_i  input  4  data nibble {w3,w2,w1,w0}
err_mask_i  input  8  XOR mask applied to the codeword, sampled at accept; 0 means a clean transmission
valid_i  input  1  data_i and err_mask_i are valid
ready_o  output  1  block can accept a new nibble
codeword_o  output  8  registered transmitted byte, after the mask is applied
tx_o  output  1  serial line; idles high
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at the end of the stop bit

Behaviour:
- Codeword layout, bit 7 to bit 0: g0, w3, w2, w1, p2, w0, p1, p0.
- Parity equations:
  - p0 = w0^w1^w3
  - p1 = w0^w2^w3
  - p2 = w1^w2^w3
  - g0 = XOR of bits 6:0
- Transmitted byte = codeword ^ err_mask_i.
- Reset is asynchronous and takes effect immediately, including mid-frame. Reset values:
  - state = IDLE
  - tx_o = 1
  - ready_o = 1
  - busy_o = 0
  - done_o = 0
  - codeword_o = 8'h00
  - all counters = 0
- Handshake:
  - ready_o = 1 only in IDLE.
  - Accept occurs on the cycle with valid_i & ready_o.
  - On accept, the masked byte is latched into codeword_o and the shift register.
  - ready_o drops on the next cycle.
  - valid_i while busy is ignored; no queueing.
  - The input does not need to be held after accept.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_o = 1. Accept moves to START on the next edge.
  - START: tx_o = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first (bit 0 = p0 first). Each bit is held for CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7; the state advances after index 7 completes.
  - STOP: tx_o = 1 for CLKS_PER_BIT cycles. done_o pulses in the last cycle of STOP, then the FSM returns to IDLE.
- Timing:
  - The frame is exactly 10*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
  - ready_o rises in the cycle after the done_o pulse, so back-to-back frames have no extra idle bit.
- busy_o = (state != IDLE).
- The baud counter runs 0..CLKS_PER_BIT-1, wraps at the bit boundary, and is cleared on accept.
- codeword_o holds the last transmitted byte until the next accept.
- tx_o is driven from a register, with no combinational path from inputs.

Decomposition:
- Shared package hamming_pkg:
  - bit-position constants (POS_P0..POS_G0)
  - codeword typedef (logic [7:0])
  - FSM state enum
  - FRAME_BITS = 10
  The syndrome detector and this block both use the package.
- Combinational sub-module hamming_encoder, data[3:0] -> codeword[7:0], per the equations above; instantiated once.
- The top level holds the handshake, FSM, baud counter and shift register.

Test Plan:
- data_i = 4'b1011, mask 0, CLKS_PER_BIT = 4 -> codeword_o = 8'h55. tx_o sequence per 4 cycles: 0, 1,0,1,0,1,0,1,0, 1. done_o fires 40 cycles after START begins.
- data_i = 0000 -> 8'h00; 1111 -> 8'hFF; 0001 -> 8'h87. Loop all 16 nibbles through the syndrome detector: syndrome is 4'b0000 in every case.
- data_i = 1011, err_mask_i = 8'h04 -> codeword_o = 8'h51. The detector on the received byte gives syndrome 4'b1011. Mask 8'h05 gives a nonzero {s2,s1,s0} with s3 = 0, the double-error signature.
- valid_i held high continuously -> frames back-to-back, ready_o high for exactly one cycle between frames. valid_i toggling mid-frame is ignored and does not alter tx_o.
- rst_n asserted during DATA bit 3 -> tx_o = 1, busy_o = 0, ready_o = 1 immediately, with no clock edge needed. After release, a new accept starts a clean frame.
- CLKS_PER_BIT = 2 -> frame length is 20 cycles and bit boundaries are exact.
